// File: rtl/mat_operand_packer_if.sv
`default_nettype none
// ============================================================================
// mat_operand_packer_if : element, weight and packed-group bus of the packer
// Revision 1.0
// ============================================================================
interface mat_operand_packer_if #(
    parameter int MAT_WIDTH = 4,
    parameter int ACT_W     = 24,
    parameter int WGT_W     = 18
);
    logic                       mode;
    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 in_data;
    logic                       in_last;
    logic                       w_valid;
    logic [15:0]                w_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [MAT_WIDTH*ACT_W-1:0] I_A;
    logic [WGT_W-1:0]           I_B;
    logic                       out_mode;

    modport slave (
        input  mode, in_valid, in_data, in_last, w_valid, w_data, out_ready,
        output in_ready, out_valid, I_A, I_B, out_mode
    );

    modport master (
        output mode, in_valid, in_data, in_last, w_valid, w_data, out_ready,
        input  in_ready, out_valid, I_A, I_B, out_mode
    );
endinterface
`default_nettype wire

// File: rtl/mat_operand_packer.sv
`default_nettype none
// ============================================================================
// mat_operand_packer : packs 8-bit / 1-bit activations and weights for DSP lanes
// Revision 1.0
// ============================================================================
module mat_operand_packer #(
    parameter int MAT_WIDTH = 4,
    parameter int ACT_W     = 24,
    parameter int WGT_W     = 18
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mat_operand_packer_if.slave  bus
);
    localparam int C_NSLOT = 2 * MAT_WIDTH;
    localparam int C_CNT_W = (C_NSLOT > 1) ? $clog2(C_NSLOT) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_NSLOT - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [C_CNT_W-1:0]         r_count;
    logic [7:0]                 r_slot [C_NSLOT];
    logic                       r_grp_mode;
    logic [15:0]                r_weight;
    logic [MAT_WIDTH*ACT_W-1:0] r_pend_a;
    logic [WGT_W-1:0]           r_pend_b;
    logic                       r_pend_mode;
    logic [MAT_WIDTH*ACT_W-1:0] r_out_a;
    logic [WGT_W-1:0]           r_out_b;
    logic                       r_out_mode;
    logic                       r_out_valid;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_group_end;
    logic                       w_complete;
    logic                       w_out_free;
    logic                       w_drain;
    logic                       w_pack_mode;
    logic                       w_load_new;
    logic                       w_load_pend;
    logic                       w_park;
    logic [7:0]                 w_elem [C_NSLOT];
    logic [MAT_WIDTH*ACT_W-1:0] w_pack_a;
    logic [WGT_W-1:0]           w_pack_b;
    logic [WGT_W-1:0]           w_w0;
    logic [WGT_W-1:0]           w_w1;

    assign w_in_ready  = (r_state == S_FILL);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_group_end = bus.in_valid && (bus.in_last || (r_count == C_LAST));
    assign w_complete  = w_accept && w_group_end;
    assign w_drain     = r_out_valid && bus.out_ready;
    assign w_out_free  = !r_out_valid || bus.out_ready;
    // A one-element group completes at slot 0, before the mode has been latched
    assign w_pack_mode = (r_count == '0) ? bus.mode : r_grp_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_pend = 1'b0;
        w_park      = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_group_end) begin
                    if (w_out_free) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_park      = 1'b1;
                        w_state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (w_drain) begin
                    w_load_pend = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Current group as it would look with the element on the bus included
    always_comb begin
        for (int k = 0; k < C_NSLOT; k++) begin
            w_elem[k] = (C_CNT_W'(k) == r_count) ? bus.in_data : r_slot[k];
        end
    end

    generate
        for (genvar j = 0; j < MAT_WIDTH; j++) begin : g_lane
            logic [ACT_W-1:0] w_lo;
            logic [ACT_W-1:0] w_hi;
            logic [ACT_W-1:0] w_bit_lo;
            logic [ACT_W-1:0] w_bit_hi;

            assign w_lo     = {{(ACT_W-8){w_elem[2*j][7]}}, w_elem[2*j]};
            assign w_hi     = {{(ACT_W-8){w_elem[2*j+1][7]}}, w_elem[2*j+1]};
            assign w_bit_lo = {{(ACT_W-1){1'b0}}, w_elem[2*j][0]};
            assign w_bit_hi = {{(ACT_W-1){1'b0}}, w_elem[2*j+1][0]};

            assign w_pack_a[j*ACT_W +: ACT_W] = w_pack_mode
                                              ? (w_bit_lo | (w_bit_hi << 16))
                                              : (w_lo + (w_hi << 16));
        end
    endgenerate

    assign w_w0     = {{(WGT_W-8){r_weight[7]}}, r_weight[7:0]};
    assign w_w1     = {{(WGT_W-8){r_weight[15]}}, r_weight[15:8]};
    assign w_pack_b = w_pack_mode ? (w_w0 + (w_w1 << 8)) : w_w0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_grp_mode  <= 1'b0;
            r_weight    <= '0;
            r_pend_a    <= '0;
            r_pend_b    <= '0;
            r_pend_mode <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_mode  <= 1'b0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < C_NSLOT; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            if (bus.w_valid) begin
                r_weight <= bus.w_data;
            end

            if (w_accept) begin
                if (r_count == '0) begin
                    r_grp_mode <= bus.mode;
                end
                // Slots are zeroed after each group so short groups pad with zeros
                if (w_complete) begin
                    r_count <= '0;
                    for (int k = 0; k < C_NSLOT; k++) begin
                        r_slot[k] <= '0;
                    end
                end else begin
                    r_count         <= r_count + C_CNT_W'(1);
                    r_slot[r_count] <= bus.in_data;
                end
            end

            if (w_park) begin
                r_pend_a    <= w_pack_a;
                r_pend_b    <= w_pack_b;
                r_pend_mode <= w_pack_mode;
            end

            if (w_load_new) begin
                r_out_a     <= w_pack_a;
                r_out_b     <= w_pack_b;
                r_out_mode  <= w_pack_mode;
                r_out_valid <= 1'b1;
            end else if (w_load_pend) begin
                r_out_a     <= r_pend_a;
                r_out_b     <= r_pend_b;
                r_out_mode  <= r_pend_mode;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.I_A       = r_out_a;
    assign bus.I_B       = r_out_b;
    assign bus.out_mode  = r_out_mode;
endmodule
`default_nettype wire

// File: tb/tb_mat_operand_packer.sv
`default_nettype none
// ============================================================================
// tb_mat_operand_packer : directed and randomized checks against a group model
// Revision 1.0
// ============================================================================
module tb_mat_operand_packer;
    localparam int MW = 4;
    localparam int AW = 24;
    localparam int WW = 18;
    localparam int NS = 2 * MW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mat_operand_packer_if #(.MAT_WIDTH(MW), .ACT_W(AW), .WGT_W(WW)) bus ();

    mat_operand_packer #(.MAT_WIDTH(MW), .ACT_W(AW), .WGT_W(WW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW*AW-1:0] a;
        logic [WW-1:0]    b;
        logic             m;
    } grp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_elems [$];
    logic       m_mode;
    logic [15:0] m_w;
    grp_t       m_out;
    grp_t       m_pend;
    bit         m_out_v  = 1'b0;
    bit         m_pend_v = 1'b0;
    bit         rnd_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Packed group from the collected elements using plain integer arithmetic
    function automatic grp_t build(input logic md, input logic [15:0] w);
        grp_t g;
        int   lo, hi, lane, b0, b1;
        g.a = '0;
        g.m = md;
        for (int j = 0; j < MW; j++) begin
            logic [7:0] e0, e1;
            e0 = (2*j   < m_elems.size()) ? m_elems[2*j]   : 8'h00;
            e1 = (2*j+1 < m_elems.size()) ? m_elems[2*j+1] : 8'h00;
            if (md) begin
                lane = int'(e0[0]) + 65536 * int'(e1[0]);
            end else begin
                lo   = $signed(e0);
                hi   = $signed(e1);
                lane = lo + hi * 65536;
            end
            g.a[j*AW +: AW] = AW'(lane);
        end
        b0  = $signed(w[7:0]);
        b1  = $signed(w[15:8]);
        g.b = md ? WW'(b0 + b1 * 256) : WW'(b0);
        return g;
    endfunction

    task automatic tick();
        grp_t g;
        bit   old_v, acc;
        if (rnd_en) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.w_valid   = ($urandom_range(0, 4) == 0);
            bus.w_data    = 16'($urandom);
        end
        if (!reset) begin
            check_eq("in_ready", bus.in_ready, !m_pend_v);
            check_eq("out_valid", bus.out_valid, m_out_v);
            if (m_out_v) begin
                check_eq("I_A", bus.I_A, m_out.a);
                check_eq("I_B", bus.I_B, m_out.b);
                check_eq("out_mode", bus.out_mode, m_out.m);
            end
        end
        if (reset) begin
            m_elems.delete();
            m_out_v  = 1'b0;
            m_pend_v = 1'b0;
            m_w      = '0;
            m_mode   = 1'b0;
        end else begin
            old_v = m_out_v;
            acc   = bus.in_valid && !m_pend_v;
            if (m_pend_v) begin
                if (bus.out_ready) begin
                    m_out    = m_pend;
                    m_pend_v = 1'b0;
                end
            end else begin
                if (old_v && bus.out_ready) m_out_v = 1'b0;
                if (acc) begin
                    if (m_elems.size() == 0) m_mode = bus.mode;
                    m_elems.push_back(bus.in_data);
                    if (bus.in_last || m_elems.size() == NS) begin
                        g = build(m_mode, m_w);
                        m_elems.delete();
                        if (!old_v || bus.out_ready) begin
                            m_out   = g;
                            m_out_v = 1'b1;
                        end else begin
                            m_pend   = g;
                            m_pend_v = 1'b1;
                        end
                    end
                end
            end
            if (bus.w_valid) m_w = bus.w_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic md, input logic [7:0] d, input logic l);
        bit done = 1'b0;
        bus.mode     = md;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = !m_pend_v;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_eq("send_accepted", done, 1);
    endtask

    task automatic wload(input logic [15:0] d);
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        tick();
        bus.w_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] v028 [8];
        logic [7:0] v029 [8];
        v028 = '{8'h03, 8'hFE, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        v029 = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_I_A", bus.I_A, 0);
        check_eq("rst_I_B", bus.I_B, 0);
        check_eq("rst_out_mode", bus.out_mode, 0);

        // 8x8 example group
        wload(16'h0080);
        for (int i = 0; i < NS; i++) send(1'b0, v028[i], 1'b0);
        check_eq("ex0_valid", bus.out_valid, 1);
        check_eq("ex0_I_A", bus.I_A, {24'h000000, 24'h000000, 24'h00FFFF, 24'hFE0003});
        check_eq("ex0_I_B", bus.I_B, 18'h3FF80);

        // 1x8 example group
        wload(16'hFD05);
        for (int i = 0; i < NS; i++) send(1'b1, v029[i], 1'b0);
        check_eq("ex1_I_A", bus.I_A, {24'h000000, 24'h000001, 24'h010000, 24'h010001});
        check_eq("ex1_I_B", bus.I_B, 18'h3FD05);
        check_eq("ex1_mode", bus.out_mode, 1);

        // short group closed by in_last
        send(1'b0, 8'h07, 1'b0);
        send(1'b0, 8'h07, 1'b0);
        send(1'b0, 8'h07, 1'b1);
        check_eq("last_I_A", bus.I_A, {24'h000000, 24'h000000, 24'h000007, 24'h070007});

        // back-pressure: two groups, second parks until one drain cycle
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2*NS; i++) send(1'b0, 8'($urandom), 1'b0);
        check_eq("bp_in_ready_full", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("bp_in_ready_free", bus.in_ready, 1);
        check_eq("bp_out_valid", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b1;
        tick();

        // reset mid-group discards the partial group and the weight
        for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < NS; i++) send(1'b0, 8'($urandom), 1'b0);
        tick();

        // mode toggled mid-group
        for (int i = 0; i < 3; i++) send(1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) send(1'b1, 8'($urandom), 1'b0);
        check_eq("toggle_mode0", bus.out_mode, 0);
        for (int i = 0; i < NS; i++) send(1'b1, 8'($urandom), 1'b0);
        check_eq("toggle_mode1", bus.out_mode, 1);

        // randomized traffic
        rnd_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) tick();
            else send(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        rnd_en        = 1'b0;
        bus.w_valid   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/mat_operand_packer.md
MAT_OPERAND_PACKER -- requirements
Module: mat_operand_packer

Interface
REQ-001 Parameter MAT_WIDTH, default 4, number of DSP lanes per packed group (2*MAT_WIDTH activation elements per group).
REQ-002 Parameter ACT_W, default 24, width of one packed activation lane.
REQ-003 Parameter WGT_W, default 18, width of the packed weight word.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = 8x8 packing (8-bit signed activations), 1 = 1x8 packing (1-bit unsigned activations); sampled per group.
REQ-007 in_valid / in_ready / in_data[7:0] / in_last  input/output/input/input  activation element stream with a valid/ready handshake; in_last marks the final element of a stream.
REQ-008 w_valid / w_data[15:0]  input  weight load; w_data[7:0] = w0, w_data[15:8] = w1, both signed.
REQ-009 out_valid  output  1  a packed group is held on I_A/I_B.
REQ-010 out_ready  input  1  consumer accepts the group.
REQ-011 I_A  output  MAT_WIDTH*ACT_W  packed activation lanes; lane j = I_A[j*ACT_W +: ACT_W].
REQ-012 I_B  output  WGT_W  packed weight word.
REQ-013 out_mode  output  1  mode the held group was packed with.

Function
REQ-014 Elements accepted on in_valid && in_ready, count 0..2*MAT_WIDTH-1, element k stored in slot k.
REQ-015 mode is latched when slot 0 is accepted; a mode change takes effect only on the next group.
REQ-016 Weight register loaded on every w_valid cycle (always ready); I_B is packed from the weight register value in the cycle of group completion.
REQ-017 Group completes when the last slot is accepted, or when an element with in_last=1 is accepted; unfilled slots are zero.
REQ-018 FSM FILL/FULL: FILL accepts elements; on completion, if the output stage is empty or is being drained this cycle, the group moves to the output register next edge and count resets to 0; otherwise the FSM enters FULL.
REQ-019 FULL: in_ready=0; the group moves to the output register on the edge where out_valid && out_ready, then the FSM returns to FILL.
REQ-020 in_ready = 1 in FILL, 0 in FULL; combinational from state only.
REQ-021 Latency: completing element accepted at edge t -> out_valid=1 with that group after edge t (next cycle) when the output stage is free.
REQ-022 out_valid stays 1 and I_A/I_B/out_mode are held stable until out_valid && out_ready; simultaneous drain and load in the same cycle keeps out_valid=1 with the new group.
REQ-023 Mode 0 lane j = (sext24(e[2j]) + (sext24(e[2j+1]) << 16)) mod 2^24; I_B = sext18(w0).
REQ-024 Mode 1 lane j = e[2j][0] | (e[2j+1][0] << 16); I_B = (sext18(w0) + (sext18(w1) << 8)) mod 2^18.
REQ-025 in_last with an empty FILL buffer is impossible by construction (in_last is carried on an accepted element); in_last on slot 2*MAT_WIDTH-1 behaves as a normal completion.

Reset
REQ-026 On reset: state FILL, count 0, out_valid 0, I_A 0, I_B 0, out_mode 0, weight register 0, partial group discarded.
REQ-027 Reset asserted mid-group or while a group is held discards all data; in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-028 Mode 0, w_data=0x0080, elements 3,-2,-1,1,0,0,0,0 -> one cycle later out_valid=1, lane0=0xFE0003, lane1=0x00FFFF, lanes2-3=0, I_B=0x3FF80.
REQ-029 Mode 1, w0=5, w1=-3, elements 1,1,0,1,1,0,0,0 -> lane0=0x010001, lane1=0x010000, lane2=0x000001, lane3=0, I_B=0x3FD05.
REQ-030 out_ready=0, feed 16 elements -> first group held unchanged, second group fills, in_ready=0 after element 16; out_ready=1 for one cycle -> second group appears next cycle, in_ready=1.
REQ-031 Mode 0, 3 elements 7,7,7 with in_last on the third -> lane0=0x070007, lane1=0x000007, lanes2-3=0.
REQ-032 Reset asserted after 5 elements accepted -> out_valid=0, next 8 elements form a clean group with no residue.
REQ-033 mode toggled mid-group -> out_mode equals the mode at slot 0; the following group uses the new mode.
